// File: rtl/rambit_bist_pkg.sv
// Shared types and March C- element tables for the RAM BIST engine.
package rambit_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;

  // Per-element properties, bit k describes element Ek (bits 6..7 unused).
  localparam logic [7:0] ELEM_RD   = 8'b0011_1110;  // element reads
  localparam logic [7:0] ELEM_WR   = 8'b0001_1111;  // element writes
  localparam logic [7:0] ELEM_WVAL = 8'b0000_1010;  // value written (solid)
  localparam logic [7:0] ELEM_EXP  = 8'b0001_0100;  // value expected (solid)
  localparam logic [7:0] ELEM_UP   = 8'b0010_0111;  // 1 = ascending order

endpackage

// File: rtl/rambit.sv
// Bit-masked single-port RAM with registered read data (read-before-write).
module rambit #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          ce,
  input  logic [DW-1:0] we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array has no reset; clearing every word would force it into flops.
  always_ff @(posedge clk) begin
    if (ce) begin
      dout      <= mem[addr];
      mem[addr] <= (mem[addr] & ~we) | (din & we);
    end
  end

endmodule

// File: rtl/rambit_bist.sv
// March C- BIST engine: drives the RAM port, checks read data one cycle later,
// and latches the first miscompare.
module rambit_bist
  import rambit_bist_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [2:0]    fail_elem,
  output logic          mem_ce,
  output logic [DW-1:0] mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  state_e        state, state_d;
  logic [2:0]    elem, elem_d;
  logic          busy_d, done_d, fail_d;
  logic [AW-1:0] fail_addr_d;
  logic [2:0]    fail_elem_d;
  logic          ce_d;
  logic [DW-1:0] we_d, din_d;
  logic [AW-1:0] addr_d;
  logic          chk_vld, chk_vld_d, chk_exp, chk_exp_d;
  logic [AW-1:0] chk_addr, chk_addr_d;
  logic [2:0]    chk_elem, chk_elem_d;

  logic          issue;
  logic [2:0]    issue_elem, next_elem;
  logic [AW-1:0] issue_addr, last_addr;
  logic          miscmp;

  assign miscmp    = chk_vld && (mem_dout != {DW{chk_exp}});
  assign last_addr = ELEM_UP[elem] ? '1 : '0;
  assign next_elem = elem + 3'd1;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state;
    busy_d      = busy;
    done_d      = done;
    fail_d      = fail;
    fail_addr_d = fail_addr;
    fail_elem_d = fail_elem;
    issue       = 1'b0;
    issue_elem  = E0;
    issue_addr  = '0;
    ce_d        = 1'b0;
    we_d        = '0;
    din_d       = '0;
    addr_d      = '0;
    elem_d      = E0;

    // Capture what the read now on the port should return.
    chk_vld_d  = (state == S_RUN) && ELEM_RD[elem];
    chk_exp_d  = ELEM_EXP[elem];
    chk_addr_d = mem_addr;
    chk_elem_d = elem;

    if (miscmp && !fail) begin
      fail_d      = 1'b1;
      fail_addr_d = chk_addr;
      fail_elem_d = chk_elem;
    end

    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
          issue       = 1'b1;
        end
      end
      S_RUN: begin
        if (mem_addr != last_addr) begin
          issue      = 1'b1;
          issue_elem = elem;
          issue_addr = ELEM_UP[elem] ? mem_addr + AW'(1) : mem_addr - AW'(1);
        end else if (elem == E5) begin
          state_d = S_DRAIN;
        end else begin
          // Element boundary: jump straight to the next element's first address.
          issue      = 1'b1;
          issue_elem = next_elem;
          issue_addr = ELEM_UP[next_elem] ? '0 : '1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      ce_d   = 1'b1;
      we_d   = {DW{ELEM_WR[issue_elem]}};
      din_d  = {DW{ELEM_WVAL[issue_elem]}};
      addr_d = issue_addr;
      elem_d = issue_elem;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      elem      <= E0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      mem_ce    <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_din   <= '0;
      chk_vld   <= 1'b0;
      chk_exp   <= 1'b0;
      chk_addr  <= '0;
      chk_elem  <= '0;
    end else begin
      state     <= state_d;
      elem      <= elem_d;
      busy      <= busy_d;
      done      <= done_d;
      fail      <= fail_d;
      fail_addr <= fail_addr_d;
      fail_elem <= fail_elem_d;
      mem_ce    <= ce_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_din   <= din_d;
      chk_vld   <= chk_vld_d;
      chk_exp   <= chk_exp_d;
      chk_addr  <= chk_addr_d;
      chk_elem  <= chk_elem_d;
    end
  end

endmodule
